ffra_sched: RTL

- Round-robin scheduler that shares one 8x8+16 arithmetic datapath (operands a, b, ci; 16-bit result o) among NREQ requesters.
- Accepts operand requests over per-requester valid/ready handshakes, issues at most one operation per cycle, and tracks in-flight operations through the fixed datapath latency.
- Returns each result tagged with the requester id.
- Supports per-requester chaining: the requester's previous result is used as ci, with hazard stalling.

---
 rtl/ffra_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ffra_sched.sv
// Round-robin scheduler sharing one a*b+ci datapath among NREQ requesters.
// Tracks in-flight ops by id, returns tagged results, and supports per-requester chaining.
module ffra_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_chain,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    input  logic [16*NREQ-1:0]  req_ci,
    output logic [7:0]          mac_a,
    output logic [7:0]          mac_b,
    output logic [15:0]         mac_ci,
    input  logic [15:0]         mac_o,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_data
);

    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [NREQ-1:0][15:0]     acc_q, acc_d;
    logic [LAT-1:0]            pipe_vld_q, pipe_vld_d;
    logic [LAT-1:0][IDW-1:0]   pipe_id_q, pipe_id_d;
    logic [7:0]                mac_a_q, mac_a_d;
    logic [7:0]                mac_b_q, mac_b_d;
    logic [15:0]               mac_ci_q, mac_ci_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]            rsp_id_q, rsp_id_d;
    logic [15:0]               rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]           busy;
    logic [NREQ-1:0]           elig;
    logic                      gnt_vld;
    logic [IDW-1:0]            gnt_id;
    logic                      done;
    logic [IDW-1:0]            done_id;

    // A chained requester must wait until none of its ops remain in the tracking pipe,
    // which is exactly when acc holds its newest result (no bypass path).
    always_comb begin
        busy = '0;
        for (int j = 0; j < LAT; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pipe_vld_q[j] && (pipe_id_q[j] == IDW'(i))) begin
                    busy[i] = 1'b1;
                end
            end
        end
        elig = req_valid & ~(req_chain & busy);
    end

    // Scan from the highest offset down so the first eligible slot at/after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign done    = pipe_vld_q[LAT-1];
    assign done_id = pipe_id_q[LAT-1];

    always_comb begin
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        mac_ci_d    = mac_ci_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_id_d   = pipe_id_q;
        rsp_valid_d = done;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        pipe_vld_d[0] = gnt_vld;
        pipe_id_d[0]  = gnt_id;
        for (int j = 1; j < LAT; j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_id_d[j]  = pipe_id_q[j-1];
        end

        if (gnt_vld) begin
            ptr_d    = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            mac_a_d  = req_a[int'(gnt_id)*8 +: 8];
            mac_b_d  = req_b[int'(gnt_id)*8 +: 8];
            mac_ci_d = req_chain[gnt_id] ? acc_q[gnt_id] : req_ci[int'(gnt_id)*16 +: 16];
        end

        if (done) begin
            rsp_id_d       = done_id;
            rsp_data_d     = mac_o;
            acc_d[done_id] = mac_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            acc_q       <= '0;
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_ci_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            mac_ci_q    <= mac_ci_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_ci    = mac_ci_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
